// File: rtl/nthash_engine.sv
// nthash_engine: single-block NT/MD4 hash lane.
// A password is taken in over a valid/ready handshake. It is optionally expanded
// to UTF-16LE, padded into one MD4 block and hashed by an iterative md4block core.
// The byte-serialised digest is returned over a second valid/ready handshake.

// md4block: iterative MD4 compression, one step per clock (48 steps).
// Starts on irdy while idle; irdy seen while busy is ignored. ordy pulses for one
// cycle when newstate_* is valid. newstate_* then holds until the next start.
// blk and state_* must be held stable while the core is busy.
module md4block (
   input  logic         clk,
   input  logic         nrst,
   input  logic         irdy,
   input  logic [511:0] blk,
   input  logic [31:0]  state_a,
   input  logic [31:0]  state_b,
   input  logic [31:0]  state_c,
   input  logic [31:0]  state_d,
   output logic         ordy,
   output logic [31:0]  newstate_a,
   output logic [31:0]  newstate_b,
   output logic [31:0]  newstate_c,
   output logic [31:0]  newstate_d
);
   logic        busy;
   logic [5:0]  step;
   logic [31:0] a, b, c, d;
   logic [3:0]  i, k;
   logic [4:0]  s;
   logic [31:0] f, kc, x, w, sum, nw;

   // Round function, message word index, constant and rotation for the current step
   always_comb begin
      i  = step[3:0];
      f  = '0;
      k  = i;
      kc = '0;
      s  = 5'd3;
      unique case (step[5:4])
         2'd0: begin
            f = (b & c) | (~b & d);
            k = i;
            kc = 32'h0;
            case (i[1:0])
               2'd0: s = 5'd3;
               2'd1: s = 5'd7;
               2'd2: s = 5'd11;
               default: s = 5'd19;
            endcase
         end
         2'd1: begin
            f = (b & c) | (b & d) | (c & d);
            k = {i[1:0], i[3:2]};
            kc = 32'h5A827999;
            case (i[1:0])
               2'd0: s = 5'd3;
               2'd1: s = 5'd5;
               2'd2: s = 5'd9;
               default: s = 5'd13;
            endcase
         end
         default: begin
            f = b ^ c ^ d;
            k = {i[0], i[1], i[2], i[3]};
            kc = 32'h6ED9EBA1;
            case (i[1:0])
               2'd0: s = 5'd3;
               2'd1: s = 5'd9;
               2'd2: s = 5'd11;
               default: s = 5'd15;
            endcase
         end
      endcase
      // message words are little-endian groups of four block bytes
      w   = blk[511 - 32*k -: 32];
      x   = {w[7:0], w[15:8], w[23:16], w[31:24]};
      sum = a + f + x + kc;
      nw  = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
   end

   // Step register: rotating a/b/c/d keeps every step in the a = FF(a,b,c,d) form
   always_ff @(posedge clk) begin
      if (!nrst) begin
         busy <= 1'b0;
         step <= '0;
         ordy <= 1'b0;
         a <= '0; b <= '0; c <= '0; d <= '0;
      end else begin
         ordy <= 1'b0;
         if (busy) begin
            a <= d;
            b <= nw;
            c <= b;
            d <= c;
            step <= step + 6'd1;
            if (step == 6'd47) begin
               busy <= 1'b0;
               ordy <= 1'b1;
            end
         end else if (irdy) begin
            a <= state_a; b <= state_b; c <= state_c; d <= state_d;
            step <= '0;
            busy <= 1'b1;
         end
      end
   end

   assign newstate_a = state_a + a;
   assign newstate_b = state_b + b;
   assign newstate_c = state_c + c;
   assign newstate_d = state_d + d;
endmodule

module nthash_engine #(
   parameter int MAX_CHARS = 27
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_mode,
   input  logic [5:0]             in_len,
   input  logic [8*MAX_CHARS-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [127:0]           out_hash,
   output logic                   out_err
);
   typedef enum logic [2:0] {IDLE, PAD, START1, START2, WAIT, CAPTURE, DONE} state_t;

   localparam logic [5:0] MAXC = 6'(MAX_CHARS);

   state_t                 state, nxt;
   logic                   mode_q;
   logic [5:0]             len_q;
   logic [8*MAX_CHARS-1:0] data_q;
   logic [511:0]           block_q, blk;
   logic                   irdy, ordy;
   logic [31:0]            ns_a, ns_b, ns_c, ns_d;
   logic [6:0]             in_m, mlen;
   logic [9:0]             bitlen;
   logic                   legal;
   logic [7:0]             bv;
   int                     ci;

   function automatic logic [31:0] bswap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // Legality of the incoming request (message length in bytes after expansion)
   always_comb begin
      in_m  = in_mode ? {in_len, 1'b0} : {1'b0, in_len};
      legal = (in_len <= MAXC) && (in_m <= 7'd55);
   end

   // Padded block built from the captured request; only reached with m <= 55
   always_comb begin
      mlen   = mode_q ? {len_q, 1'b0} : {1'b0, len_q};
      bitlen = {mlen, 3'b000};
      blk    = '0;
      bv     = '0;
      ci     = 0;
      for (int kk = 0; kk < 64; kk++) begin
         bv = 8'h00;
         if (kk == 56) begin
            bv = bitlen[7:0];
         end else if (kk == 57) begin
            bv = {6'b0, bitlen[9:8]};
         end else if (7'(kk) < mlen) begin
            if (mode_q) ci = (kk % 2 == 0) ? kk / 2 : -1;
            else        ci = kk;
            if (ci >= 0 && ci < MAX_CHARS)
               bv = data_q[8*(MAX_CHARS-ci)-1 -: 8];
         end else if (7'(kk) == mlen) begin
            bv = 8'h80;
         end
         blk[511-8*kk -: 8] = bv;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!nrst) state <= IDLE;
      else       state <= nxt;
   end

   // Next-state logic
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (in_valid) nxt = legal ? PAD : DONE;
         PAD:     nxt = START1;
         START1:  nxt = START2;
         START2:  nxt = WAIT;
         WAIT:    if (ordy) nxt = CAPTURE;
         CAPTURE: nxt = DONE;
         DONE:    if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Request capture, block build, start pulse and result registers
   always_ff @(posedge clk) begin
      if (!nrst) begin
         mode_q   <= 1'b0;
         len_q    <= '0;
         data_q   <= '0;
         block_q  <= '0;
         irdy     <= 1'b0;
         out_hash <= '0;
         out_err  <= 1'b0;
      end else begin
         irdy <= (nxt == START1) || (nxt == START2);
         unique case (state)
            IDLE: if (in_valid) begin
               mode_q <= in_mode;
               len_q  <= in_len;
               data_q <= in_data;
               if (!legal) begin
                  out_err  <= 1'b1;
                  out_hash <= '0;
               end else begin
                  out_err <= 1'b0;
               end
            end
            PAD:     block_q <= blk;
            CAPTURE: begin
               out_hash <= {bswap(ns_a), bswap(ns_b), bswap(ns_c), bswap(ns_d)};
               out_err  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   md4block u_md4 (
      .clk        (clk),
      .nrst       (nrst),
      .irdy       (irdy),
      .blk        (block_q),
      .state_a    (32'h67452301),
      .state_b    (32'hEFCDAB89),
      .state_c    (32'h98BADCFE),
      .state_d    (32'h10325476),
      .ordy       (ordy),
      .newstate_a (ns_a),
      .newstate_b (ns_b),
      .newstate_c (ns_c),
      .newstate_d (ns_d)
   );
endmodule

// File: tb/tb_nthash_engine.sv
// Directed bench for nthash_engine: known MD4/NT digests, length limits,
// output back-pressure and reset while the core is computing.
module tb_nthash_engine;
   localparam int MC = 27;

   logic          clk = 1'b0;
   logic          nrst;
   logic          in_valid, in_ready, in_mode;
   logic [5:0]    in_len;
   logic [8*MC-1:0] in_data;
   logic          out_valid, out_ready;
   logic [127:0]  out_hash;
   logic          out_err;

   int checks = 0;
   int failures = 0;
   int irdy_cnt = 0;

   nthash_engine #(.MAX_CHARS(MC)) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_len(in_len), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_hash(out_hash), .out_err(out_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (dut.irdy === 1'b1) irdy_cnt++;

   typedef struct {
      logic         mode;
      logic [5:0]   len;
      logic [8*MC-1:0] data;
      logic [127:0] hash;
      logic         err;
      logic         chk_hash;
   } vec_t;

   vec_t tv[14];

   function automatic logic [8*MC-1:0] pack(input string s);
      logic [8*MC-1:0] d;
      d = '0;
      for (int i = 0; i < s.len() && i < MC; i++) d[8*MC-1-8*i -: 8] = s[i];
      return d;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_req(input logic m, input logic [5:0] l, input logic [8*MC-1:0] d,
                          output logic [127:0] h, output logic e, output logic ok);
      int n;
      ok = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      in_valid = 1'b1; in_mode = m; in_len = l; in_data = d;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      ok = out_valid;
      h = out_hash;
      e = out_err;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [127:0] h;
      logic e, ok;
      int n, seen;

      tv[0]  = '{1'b0, 6'd0,  pack(""),                 128'h31D6CFE0D16AE931B73C59D7E0C089C0, 1'b0, 1'b1};
      tv[1]  = '{1'b1, 6'd0,  pack(""),                 128'h31D6CFE0D16AE931B73C59D7E0C089C0, 1'b0, 1'b1};
      tv[2]  = '{1'b0, 6'd4,  pack("test"),             128'hDB346D691D7ACC4DC2625DB19F9E3F52, 1'b0, 1'b1};
      tv[3]  = '{1'b0, 6'd9,  pack("swordfish"),        128'h5E2047B913668435800AB70F839F62AB, 1'b0, 1'b1};
      tv[4]  = '{1'b0, 6'd16, pack("reindeerflotilla"), 128'hDEABAE991701C6BEECB3949552F07601, 1'b0, 1'b1};
      tv[5]  = '{1'b1, 6'd8,  pack("password"),         128'h8846F7EAEE8FB117AD06BDD830B7586C, 1'b0, 1'b1};
      tv[6]  = '{1'b0, 6'd1,  pack("a"),                128'hBDE52CB31DE33E46245E05FBDBD6FB24, 1'b0, 1'b1};
      tv[7]  = '{1'b0, 6'd3,  pack("abc"),              128'hA448017AAF21D8525FC10AE87AA6729D, 1'b0, 1'b1};
      tv[8]  = '{1'b0, 6'd14, pack("message digest"),   128'hD9130A8164549FE818874806E1C7014B, 1'b0, 1'b1};
      tv[9]  = '{1'b0, 6'd26, pack("abcdefghijklmnopqrstuvwxyz"), 128'hD79E1C308AA5BBCDEEA8ED63DF412DA9, 1'b0, 1'b1};
      tv[10] = '{1'b1, 6'd28, pack("abcdefghijklmnopqrstuvwxyz0"), 128'h0, 1'b1, 1'b1};
      tv[11] = '{1'b0, 6'd27, pack("abcdefghijklmnopqrstuvwxyz0"), 128'h0, 1'b0, 1'b0};
      tv[12] = '{1'b1, 6'd27, pack("abcdefghijklmnopqrstuvwxyz0"), 128'h0, 1'b0, 1'b0};
      tv[13] = '{1'b0, 6'd63, pack("x"),                128'h0, 1'b1, 1'b1};

      nrst = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_len = '0; in_data = '0; out_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("reset_in_ready",  {127'b0, in_ready},  128'd1);
      chk("reset_out_valid", {127'b0, out_valid}, 128'd0);
      chk("reset_out_err",   {127'b0, out_err},   128'd0);
      chk("reset_out_hash",  out_hash,            128'd0);
      nrst = 1'b1;
      @(negedge clk);

      // table of directed vectors
      for (int t = 0; t < 14; t++) begin
         irdy_cnt = 0;
         run_req(tv[t].mode, tv[t].len, tv[t].data, h, e, ok);
         chk($sformatf("vec%0d_timeout", t), {127'b0, ok}, 128'd1);
         chk($sformatf("vec%0d_err", t), {127'b0, e}, {127'b0, tv[t].err});
         if (tv[t].chk_hash) chk($sformatf("vec%0d_hash", t), h, tv[t].hash);
         chk($sformatf("vec%0d_irdy_cycles", t), 128'(irdy_cnt), tv[t].err ? 128'd0 : 128'd2);
      end

      // back-pressure: result held for 10 cycles with out_ready low
      in_valid = 1'b1; in_mode = 1'b0; in_len = 6'd3; in_data = pack("abc");
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      chk("hold_timeout", {127'b0, out_valid}, 128'd1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("hold_out_valid", {127'b0, out_valid}, 128'd1);
         chk("hold_out_hash", out_hash, 128'hA448017AAF21D8525FC10AE87AA6729D);
         chk("hold_in_ready", {127'b0, in_ready}, 128'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hold_release_out_valid", {127'b0, out_valid}, 128'd0);
      chk("hold_release_in_ready",  {127'b0, in_ready},  128'd1);

      // reset while md4block is computing: no stale result may appear
      in_valid = 1'b1; in_mode = 1'b0; in_len = 6'd4; in_data = pack("test");
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready",  {127'b0, in_ready},  128'd1);
      chk("midrst_out_valid", {127'b0, out_valid}, 128'd0);
      chk("midrst_out_hash",  out_hash,            128'd0);
      chk("midrst_irdy",      {127'b0, dut.irdy},  128'd0);
      nrst = 1'b1;
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midrst_no_stale_result", 128'(seen), 128'd0);
      run_req(1'b1, 6'd8, pack("password"), h, e, ok);
      chk("post_rst_timeout", {127'b0, ok}, 128'd1);
      chk("post_rst_hash", h, 128'h8846F7EAEE8FB117AD06BDD830B7586C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
